load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the EX/MEM pipeline register and the byte-addressable data memory; the memory reads combinationally and writes on posedge.
- Accepts one load/store request at a time and drives the memory port.
- Splits misaligned half/word accesses into sequential byte accesses.
- Returns registered, sign/zero-extended load data or a fault flag; busy stalls the pipeline.

Parameters:
- ADDR_W, 12, memory address width; memory size is 2^ADDR_W bytes.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_store  input  1  1 = store, 0 = load
- req_func3  input  3  RV32I width/sign code (Byte=0, Half=1, Word=2, ByteU=4, HalfU=5)
- req_addr  input  32  effective byte address
- req_wdata  input  32  store data, LSB-aligned
- busy  output  1  unit is not in IDLE; new requests are ignored
- resp_valid  output  1  one-cycle pulse: response ready
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_fault  output  1  access fault, qualified by resp_valid
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_func3  output  3  width code to memory
- mem_addr  output  ADDR_W  byte address to memory
- mem_wdata  output  32  write data to memory
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset (async): state=IDLE, busy=0, resp_valid=0, resp_rdata=0, resp_fault=0, byte counter=0, accumulator=0.
- mem_read/mem_write/mem_func3/mem_addr/mem_wdata are combinational from state and request. All are 0 in reset and in IDLE when no request is accepted.
- Accept condition: req_valid && !busy. The request is used in the acceptance cycle only; the unit latches what it needs for split states.
- Size: 1 for func3 0/4, 2 for 1/5, 4 for 2.
- Fault conditions (checked at acceptance), any of:
  - illegal func3 (loads: 3,6,7; stores: anything other than 0,1,2);
  - req_addr + size - 1 > 2^ADDR_W - 1, computed in 33-bit arithmetic with no wrap.
- Fault response: no memory strobe, stay in IDLE, next cycle resp_valid=1, resp_fault=1, resp_rdata=0.
- Aligned (addr mod size == 0): one memory access in the acceptance cycle, mem_func3=req_func3, mem_addr=req_addr[ADDR_W-1:0], mem_wdata=req_wdata.
  - Load: mem_rdata is registered into resp_rdata at that edge.
  - resp_valid pulses the next cycle; latency 1; busy never asserts.
- Misaligned (fault-free), state SPLIT:
  - Byte 0 is issued in the acceptance cycle, bytes 1..size-1 in consecutive SPLIT cycles at addr+k.
  - Byte accesses use func3=ByteU for loads and Byte for stores; mem_wdata[7:0] = byte k of the latched store data.
  - Loads: mem_rdata[7:0] is accumulated into byte lane k.
  - After the last byte: return to IDLE, resp_valid pulses next cycle. Load data is sign-extended (func3 1) or zero-extended (func3 5) from the accumulated width; word loads are not extended.
  - Latency = size cycles. busy=1 throughout SPLIT.
- resp_valid is a single-cycle pulse. A new request may be accepted in the same cycle resp_valid is high.
- req_valid while busy: ignored, not queued; the requester holds it.
- Reset during SPLIT: strobes drop immediately. Bytes already written remain in memory; the remaining bytes are never written. No response is produced.
- resp_rdata holds its value until the next response.

Optional Feature:
- Macro MISALIGNED_TRAP_EN.
- Defined: misaligned accesses are treated as faults (1-cycle fault response, no memory access). The SPLIT state is not compiled.
- Undefined: misaligned accesses are split as described above.

Test Plan:
- Preload word 17 at byte 500. lw addr 500 -> mem_read 1 cycle; next cycle resp_valid=1, resp_rdata=0x00000011, busy stays 0.
- Preload bytes 500..504 = 11,00,00,00,09. lw addr 501 -> busy high for 3 cycles, mem_addr sequence 501,502,503,504; resp_rdata=0x09000000 at cycle 4.
- sh 0xABCD at addr 501 -> two byte writes: mem[501]=0xCD, mem[502]=0xAB. Then lh 501 -> 0xFFFFABCD; lhu 501 -> 0x0000ABCD.
- lw addr 0xFFE and lb addr 0x1000 -> no strobes; resp_fault=1, resp_rdata=0. sw with func3=4 -> fault.
- sw 0x44332211 at addr 0x101; assert rst after the second byte -> mem[0x101]=0x11, mem[0x102]=0x22, mem[0x103..0x104] unchanged, resp_valid never pulses, busy=0.
- With MISALIGNED_TRAP_EN defined: lw addr 501 -> resp_fault=1 after 1 cycle, no mem_read.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the pipeline-side request/response handshake and the data-memory
//   port of the load/store unit.
//   slave  : the load/store unit (takes requests, drives the memory port)
//   master : the environment (pipeline stage plus data memory)
//   Request : req_valid, req_store, req_func3[2:0], req_addr[31:0], req_wdata[31:0]
//   Response: busy, resp_valid, resp_rdata[31:0], resp_fault
//   Memory  : mem_read, mem_write, mem_func3[2:0], mem_addr[ADDR_W-1:0],
//             mem_wdata[31:0], mem_rdata[31:0] (combinational read data)
interface load_store_unit_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_store;
  logic [2:0]        req_func3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              busy;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_store, req_func3, req_addr, req_wdata, mem_rdata,
    output busy, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_func3, req_addr, req_wdata, mem_rdata,
    input  busy, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Executes one RV32I load/store at a time against a byte-addressable data
//   memory (combinational read, write on posedge). Aligned accesses take one
//   memory cycle; misaligned half/word accesses are split into byte accesses
//   issued on consecutive cycles. Illegal width codes and accesses running
//   past the top of memory return a fault without touching memory.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - load_store_unit_if.slave (request, response and memory port)
//   Build option:
//     MISALIGNED_TRAP_EN - when defined, misaligned accesses fault instead of
//                          being split and the SPLIT state is not built.
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  load_store_unit_if.slave     bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  localparam logic [2:0] F_B  = 3'd0;
  localparam logic [2:0] F_H  = 3'd1;
  localparam logic [2:0] F_BU = 3'd4;
  localparam logic [2:0] F_HU = 3'd5;

  logic [0:0]        state_reg;
  logic [1:0]        cnt_reg;
  logic [1:0]        last_reg;
  logic [31:0]       acc_reg;
  logic [2:0]        func3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              store_reg;
  logic              resp_valid_reg;
  logic              resp_fault_reg;
  logic [31:0]       resp_rdata_reg;

  logic              accept;
  logic [2:0]        size;
  logic              illegal;
  logic              out_of_range;
  logic              misaligned;
  logic              fault;
  logic [32:0]       end_addr;
  logic [31:0]       acc_next;

  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  function automatic logic [31:0] extend_load(input logic [2:0] f, input logic [31:0] d);
    case (f)
      F_B:     return {{24{d[7]}}, d[7:0]};
      F_BU:    return {24'd0, d[7:0]};
      F_H:     return {{16{d[15]}}, d[15:0]};
      F_HU:    return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Gating with rst keeps every strobe low while reset is held, even if a
  // request is presented at the same time.
  assign accept = bus.req_valid && (state_reg == IDLE) && !rst;

  always_comb begin
    case (bus.req_func3[1:0])
      2'd0:    size = 3'd1;
      2'd1:    size = 3'd2;
      default: size = 3'd4;
    endcase
    if (bus.req_store) begin
      illegal = bus.req_func3 > 3'd2;
    end else begin
      illegal = (bus.req_func3 == 3'd3) || (bus.req_func3 == 3'd6) || (bus.req_func3 == 3'd7);
    end
    // 33-bit end address so a request near 2^32 cannot wrap back into range.
    end_addr     = {1'b0, bus.req_addr} + {30'd0, size} - 33'd1;
    out_of_range = |end_addr[32:ADDR_W];
    misaligned   = ((size == 3'd2) && bus.req_addr[0]) ||
                   ((size == 3'd4) && (bus.req_addr[1:0] != 2'd0));
`ifdef MISALIGNED_TRAP_EN
    fault = illegal || out_of_range || misaligned;
`else
    fault = illegal || out_of_range;
`endif
  end

  // Accumulator with the byte returned this cycle dropped into lane cnt_reg.
  always_comb begin
    acc_next = acc_reg;
    acc_next[8*cnt_reg +: 8] = bus.mem_rdata[7:0];
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = 3'd0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (accept && !fault) begin
      mem_read  = !bus.req_store;
      mem_write = bus.req_store;
      mem_addr  = bus.req_addr[ADDR_W-1:0];
      mem_func3 = bus.req_func3;
      mem_wdata = bus.req_wdata;
`ifdef MISALIGNED_TRAP_EN
`else
      // First byte of a split access goes out in the acceptance cycle.
      if (misaligned) begin
        mem_func3 = bus.req_store ? F_B : F_BU;
        mem_wdata = {24'd0, bus.req_wdata[7:0]};
      end
`endif
    end
`ifdef MISALIGNED_TRAP_EN
`else
    else if ((state_reg == SPLIT) && !rst) begin
      mem_read  = !store_reg;
      mem_write = store_reg;
      mem_func3 = store_reg ? F_B : F_BU;
      mem_addr  = addr_reg + ADDR_W'(cnt_reg);
      mem_wdata = {24'd0, wdata_reg[8*cnt_reg +: 8]};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 2'd0;
      last_reg       <= 2'd0;
      acc_reg        <= 32'd0;
      func3_reg      <= 3'd0;
      addr_reg       <= '0;
      wdata_reg      <= 32'd0;
      store_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_fault_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
    end else begin
      resp_valid_reg <= 1'b0;
      if (accept) begin
        if (fault) begin
          resp_valid_reg <= 1'b1;
          resp_fault_reg <= 1'b1;
          resp_rdata_reg <= 32'd0;
        end
`ifdef MISALIGNED_TRAP_EN
`else
        else if (misaligned) begin
          state_reg <= SPLIT;
          cnt_reg   <= 2'd1;
          last_reg  <= 2'(size - 3'd1);
          acc_reg   <= {24'd0, bus.mem_rdata[7:0]};
          func3_reg <= bus.req_func3;
          addr_reg  <= bus.req_addr[ADDR_W-1:0];
          wdata_reg <= bus.req_wdata;
          store_reg <= bus.req_store;
        end
`endif
        else begin
          resp_valid_reg <= 1'b1;
          resp_fault_reg <= 1'b0;
          resp_rdata_reg <= bus.req_store ? 32'd0 : extend_load(bus.req_func3, bus.mem_rdata);
        end
      end
`ifdef MISALIGNED_TRAP_EN
`else
      else if (state_reg == SPLIT) begin
        acc_reg <= acc_next;
        if (cnt_reg == last_reg) begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b1;
          resp_fault_reg <= 1'b0;
          resp_rdata_reg <= store_reg ? 32'd0 : extend_load(func3_reg, acc_next);
        end else begin
          cnt_reg <= cnt_reg + 2'd1;
        end
      end
`endif
    end
  end

  assign bus.busy       = (state_reg == SPLIT);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_fault = resp_fault_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_func3  = mem_func3;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Drives directed and random load/store requests into load_store_unit and
//   checks latency, fault flag, load data, strobe counts, busy cycles and the
//   issued byte-address sequence against a byte-array reference memory.
module tb_load_store_unit;
  localparam int ADDR_W   = 12;
  localparam int MEM_SIZE = 4096;
`ifdef MISALIGNED_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();
  load_store_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory attached to the DUT, and the reference image the model reads.
  logic [7:0] mem     [0:MEM_SIZE-1];
  logic [7:0] ref_mem [0:MEM_SIZE-1];

  logic [11:0] ra1, ra2, ra3;
  assign ra1 = bus.mem_addr + 12'd1;
  assign ra2 = bus.mem_addr + 12'd2;
  assign ra3 = bus.mem_addr + 12'd3;
  assign bus.mem_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[bus.mem_addr]};

  always @(posedge clk) begin
    int w;
    if (bus.mem_write === 1'b1) begin
      w = (bus.mem_func3[1:0] == 2'd0) ? 1 : (bus.mem_func3[1:0] == 2'd1) ? 2 : 4;
      for (int i = 0; i < w; i++) mem[(int'(bus.mem_addr) + i) % MEM_SIZE] <= bus.mem_wdata[8*i +: 8];
    end
  end

  int checks = 0;
  int passed = 0;
  int rd_cnt, wr_cnt, busy_cnt;
  int addr_q[$];
  logic [31:0] last_rd = 32'd0;

  always @(negedge clk) begin
    if (bus.mem_read === 1'b1) rd_cnt++;
    if (bus.mem_write === 1'b1) wr_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) addr_q.push_back(int'(bus.mem_addr));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // Little-endian assembly from the reference image, then extension by arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    int sz;
    longint v;
    sz = size_of(f3);
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_mem[a + i]) << (8 * i);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic poke(input int a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic clear_monitor();
    rd_cnt = 0;
    wr_cnt = 0;
    busy_cnt = 0;
    addr_q.delete();
  endtask

  // Issues one request (caller is at posedge+1 with the unit idle) and
  // returns at posedge+1 of the response cycle.
  task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string name);
    int sz, lat, exp_lat, exp_strobes, exp_busy;
    bit legal, oor, mis, fault, got, ok;
    longint last;
    logic [31:0] exp_rd;
    int exp_q[$];
    sz    = size_of(f3);
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    last  = longint'(addr) + sz - 1;
    oor   = last > MEM_SIZE - 1;
    mis   = (addr % sz) != 0;
    fault = !legal || oor || (TRAP && mis);
    if (fault) begin
      exp_lat = 1; exp_strobes = 0; exp_busy = 0; exp_rd = 32'd0;
    end else begin
      exp_lat     = mis ? sz : 1;
      exp_busy    = mis ? sz - 1 : 0;
      exp_strobes = mis ? sz : 1;
      for (int k = 0; k < exp_strobes; k++) exp_q.push_back(int'(addr) + k);
      exp_rd = st ? 32'd0 : model_load(f3, int'(addr));
    end
    clear_monitor();
    bus.req_store = st; bus.req_func3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 12) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat++;
      if (bus.resp_valid === 1'b1) got = 1;
    end
    $display("%s %s f3=%0d addr=0x%h wdata=0x%h -> lat=%0d fault=%b rdata=0x%h",
             name, st ? "ST" : "LD", f3, addr, wd, lat, bus.resp_fault, bus.resp_rdata);
    checks++;
    if ((got ? lat : -1) !== exp_lat) $display("FAIL %s latency: got %0d need %0d", name, got ? lat : -1, exp_lat);
    else passed++;
    checks++;
    if (bus.resp_fault !== fault) $display("FAIL %s resp_fault: got %b need %b", name, bus.resp_fault, fault);
    else passed++;
    checks++;
    if (bus.resp_rdata !== exp_rd) $display("FAIL %s resp_rdata: got 0x%h need 0x%h", name, bus.resp_rdata, exp_rd);
    else passed++;
    checks++;
    if (rd_cnt !== (st ? 0 : exp_strobes) || wr_cnt !== (st ? exp_strobes : 0))
      $display("FAIL %s strobes: got rd=%0d wr=%0d need %0d %s", name, rd_cnt, wr_cnt, exp_strobes, st ? "writes" : "reads");
    else passed++;
    checks++;
    if (busy_cnt !== exp_busy) $display("FAIL %s busy cycles: got %0d need %0d", name, busy_cnt, exp_busy);
    else passed++;
    ok = (addr_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && addr_q[i] !== exp_q[i]) ok = 0;
    checks++;
    if (ok !== 1'b1) $display("FAIL %s mem_addr sequence: got %0d accesses need %0d", name, addr_q.size(), exp_q.size());
    else passed++;
    if (st && !fault) for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
    last_rd = exp_rd;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_func3 = 3'd2;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b need 0", bus.busy); else passed++;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL reset resp_valid: got %b need 0", bus.resp_valid); else passed++;
    checks++; if (bus.resp_rdata !== 32'd0) $display("FAIL reset resp_rdata: got 0x%h need 0", bus.resp_rdata); else passed++;
    checks++; if (bus.resp_fault !== 1'b0) $display("FAIL reset resp_fault: got %b need 0", bus.resp_fault); else passed++;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_addr !== '0)
      $display("FAIL reset strobes: got rd=%b wr=%b addr=0x%h need all 0", bus.mem_read, bus.mem_write, bus.mem_addr);
    else passed++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_plan();
    poke(500, 8'h11); poke(501, 8'h00); poke(502, 8'h00); poke(503, 8'h00); poke(504, 8'h09);
    run_req(1'b0, 3'd2, 32'd500, 32'd0, "lw_aligned");
    run_req(1'b0, 3'd2, 32'd501, 32'd0, "lw_misaligned");
    run_req(1'b1, 3'd1, 32'd501, 32'h0000ABCD, "sh_misaligned");
    run_req(1'b0, 3'd1, 32'd501, 32'd0, "lh_misaligned");
    run_req(1'b0, 3'd5, 32'd501, 32'd0, "lhu_misaligned");
    run_req(1'b0, 3'd2, 32'hFFE, 32'd0, "lw_past_top");
    run_req(1'b0, 3'd0, 32'h1000, 32'd0, "lb_out_of_range");
    run_req(1'b1, 3'd4, 32'h10, 32'h12345678, "sw_bad_func3");
    run_req(1'b0, 3'd3, 32'h10, 32'd0, "ld_bad_func3");
    run_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, "lw_wrap_addr");
  endtask

  task automatic test_back_to_back();
    run_req(1'b1, 3'd2, 32'h40, 32'h8081_F27F, "b2b_sw");
    run_req(1'b0, 3'd2, 32'h40, 32'd0, "b2b_lw");
    run_req(1'b0, 3'd0, 32'h40, 32'd0, "b2b_lb");
    run_req(1'b0, 3'd4, 32'h43, 32'd0, "b2b_lbu");
    run_req(1'b0, 3'd1, 32'h42, 32'd0, "b2b_lh");
    run_req(1'b0, 3'd5, 32'h41, 32'd0, "b2b_lhu_mis");
    @(posedge clk); #1;
    checks++;
    if (bus.resp_valid !== 1'b0) $display("FAIL b2b pulse width: got resp_valid=%b need 0", bus.resp_valid);
    else passed++;
  endtask

`ifndef MISALIGNED_TRAP_EN
  task automatic test_busy_ignore();
    logic [31:0] exp_rd;
    poke(32'h300, 8'h5A);
    for (int a = 32'h2F1; a < 32'h2F5; a++) poke(a, 8'($urandom()));
    exp_rd = model_load(3'd2, 32'h2F1);
    clear_monitor();
    bus.req_store = 1'b0; bus.req_func3 = 3'd2; bus.req_addr = 32'h2F1; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_store = 1'b1; bus.req_func3 = 3'd0; bus.req_addr = 32'h300; bus.req_wdata = 32'hA5;
    checks++; if (bus.busy !== 1'b1) $display("FAIL ignore busy: got %b need 1", bus.busy); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    $display("ignore LD addr=0x2f1 with held ST -> valid=%b rdata=0x%h writes=%0d", bus.resp_valid, bus.resp_rdata, wr_cnt);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_rd)
      $display("FAIL ignore response: got valid=%b rdata=0x%h need 1 0x%h", bus.resp_valid, bus.resp_rdata, exp_rd);
    else passed++;
    checks++;
    if (wr_cnt !== 0 || mem[32'h300] !== 8'h5A)
      $display("FAIL ignore store leaked: got writes=%0d mem=0x%h need 0 0x5a", wr_cnt, mem[32'h300]);
    else passed++;
    last_rd = exp_rd;
  endtask

  task automatic test_reset_split();
    bit seen;
    for (int a = 32'h101; a < 32'h105; a++) poke(a, 8'hEE);
    bus.req_store = 1'b1; bus.req_func3 = 3'd2; bus.req_addr = 32'h101;
    bus.req_wdata = 32'h44332211; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL split reset strobe: got wr=%b busy=%b need 0 0", bus.mem_write, bus.busy);
    else passed++;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; seen |= (bus.resp_valid === 1'b1); end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= (bus.resp_valid === 1'b1); end
    $display("split_reset ST addr=0x101 -> mem=%h %h %h %h", mem[32'h101], mem[32'h102], mem[32'h103], mem[32'h104]);
    checks++; if (seen !== 1'b0) $display("FAIL split reset response: got pulse need none"); else passed++;
    checks++;
    if ({mem[32'h101], mem[32'h102], mem[32'h103], mem[32'h104]} !== 32'h1122EEEE)
      $display("FAIL split reset memory: got %h%h%h%h need 1122eeee", mem[32'h101], mem[32'h102], mem[32'h103], mem[32'h104]);
    else passed++;
    ref_mem[32'h101] = 8'h11;
    ref_mem[32'h102] = 8'h22;
    last_rd = 32'd0;
  endtask
`endif

  task automatic test_random();
    logic [2:0] codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] f3;
    logic [31:0] addr;
    int region;
    for (int n = 0; n < 60; n++) begin
      f3 = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      region = $urandom_range(0, 9);
      if (region < 6) addr = 32'h200 + $urandom_range(0, 15);
      else if (region < 9) addr = 32'hFF8 + $urandom_range(0, 10);
      else addr = $urandom();
      run_req(1'($urandom_range(0, 1)), f3, addr, $urandom(), "rand");
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== last_rd)
          $display("FAIL rand hold: got valid=%b rdata=0x%h need 0 0x%h", bus.resp_valid, bus.resp_rdata, last_rd);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < MEM_SIZE; a++) begin
      mem[a] = 8'($urandom());
      ref_mem[a] = mem[a];
    end
    test_reset();
    test_plan();
    test_back_to_back();
`ifndef MISALIGNED_TRAP_EN
    test_busy_ignore();
    test_reset_split();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
